// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_pkg;

    typedef enum logic [1:0] {
        BYPASS,
        FILL,
        RUN
    } dl_state_e;

    function automatic int unsigned clamp_depth(input int unsigned req,
                                                input int unsigned max_depth);
        return (req > max_depth) ? max_depth : req;
    endfunction

endpackage

// File: rtl/lane_ram.sv
// One lane of delay storage: asynchronous read, synchronous write.
module lane_ram #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable multi-lane delay line with stall, flush-on-reprogram,
// bypass at depth 0 and a primed flag once the line has filled.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned LANES     = 2,
    parameter int unsigned MAX_DEPTH = 128,
    parameter int unsigned DEF_DEPTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic [LANES*WIDTH-1:0]         in,
    input  logic                           cfg_load,
    input  logic [$clog2(MAX_DEPTH+1)-1:0] cfg_depth,
    output logic                           out_valid,
    output logic [LANES*WIDTH-1:0]         out,
    output logic                           primed,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int unsigned DW = $clog2(MAX_DEPTH + 1);
    localparam int unsigned AW = $clog2(MAX_DEPTH);
    localparam dl_state_e RST_STATE = (DEF_DEPTH == 0) ? BYPASS : FILL;

    dl_state_e              state, state_next;
    logic [DW-1:0]          depth_q, depth_m1, new_depth;
    logic [DW-1:0]          ptr, fill;
    logic [AW-1:0]          addr;
    logic [MAX_DEPTH-1:0]   vbit;
    logic [LANES*WIDTH-1:0] ram_rd;
    logic                   wr;

    assign depth     = depth_q;
    assign depth_m1  = depth_q - DW'(1);
    assign new_depth = DW'(clamp_depth(32'(cfg_depth), MAX_DEPTH));
    assign addr      = ptr[AW-1:0];
    // Read and write share ptr: the slot read this cycle is then overwritten.
    assign wr        = en && !cfg_load && (state != BYPASS);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_ram #(
            .WIDTH (WIDTH),
            .DEPTH (MAX_DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .we    (wr),
            .addr  (addr),
            .wdata (in[l*WIDTH +: WIDTH]),
            .rdata (ram_rd[l*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            fill    <= '0;
            vbit    <= '0;
            depth_q <= DW'(DEF_DEPTH);
        end else if (cfg_load) begin
            ptr     <= '0;
            fill    <= '0;
            vbit    <= '0;
            depth_q <= new_depth;
        end else if (wr) begin
            vbit[addr] <= in_valid;
            ptr        <= (ptr == depth_m1) ? '0 : ptr + DW'(1);
            if (state == FILL) begin
                fill <= fill + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (cfg_load) begin
            state_next = (new_depth == '0) ? BYPASS : FILL;
        end else if (state == FILL && en && fill == depth_m1) begin
            state_next = RUN;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out       = '0;
        primed    = 1'b0;
        case (state)
            BYPASS: begin
                out_valid = in_valid & en;
                out       = out_valid ? in : '0;
                primed    = 1'b1;
            end
            FILL: begin
                out_valid = vbit[addr] & en;
                out       = out_valid ? ram_rd : '0;
            end
            RUN: begin
                out_valid = vbit[addr] & en;
                out       = out_valid ? ram_rd : '0;
                primed    = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line (DEF_DEPTH=4, MAX_DEPTH=128).
module tb_prog_delay_line;

    localparam int unsigned W  = 24;
    localparam int unsigned L  = 2;
    localparam int unsigned MD = 128;
    localparam int unsigned DD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [47:0]   in_data;
    logic          cfg_load;
    logic [7:0]    cfg_depth;
    logic          out_valid;
    logic [47:0]   out_data;
    logic          primed;
    logic [7:0]    depth;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_delay_line #(
        .WIDTH     (W),
        .LANES     (L),
        .MAX_DEPTH (MD),
        .DEF_DEPTH (DD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in        (in_data),
        .cfg_load  (cfg_load),
        .cfg_depth (cfg_depth),
        .out_valid (out_valid),
        .out       (out_data),
        .primed    (primed),
        .depth     (depth)
    );

    function automatic logic [47:0] mk(input int k);
        return {24'(k + 'h100000), 24'(k)};
    endfunction

    function automatic logic [47:0] lanes_ab(input int k);
        return {24'('hB00000 + k), 24'('hA00000 + k)};
    endfunction

    task automatic drive(input logic e, input logic v, input logic [47:0] d,
                         input logic ld, input logic [7:0] cd);
        en = e; in_valid = v; in_data = d; cfg_load = ld; cfg_depth = cd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 8'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, mk(9), 1'b0, 8'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 8'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 48'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_data); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b expected 0", primed); end
        checks++; if (depth !== 8'(DD)) begin errors++; $display("FAIL reset_depth: got %0d expected %0d", depth, DD); end
        tick();
    endtask

    task automatic test_fill_run;
        logic        ev, ep;
        logic [47:0] ed;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b1, mk(k), 1'b0, 8'd0);
            ev = (k > 4);
            ed = ev ? mk(k - 4) : 48'd0;
            ep = (k >= 5);
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL fill_valid k=%0d: got %b expected %b", k, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL fill_data k=%0d: got %h expected %h", k, out_data, ed); end
            checks++; if (primed !== ep) begin errors++; $display("FAIL fill_primed k=%0d: got %b expected %b", k, primed, ep); end
            tick();
        end
    endtask

    task automatic test_stall;
        int          k;
        logic        ev;
        logic [47:0] ed;
        do_reset();
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                k++;
                drive(1'b1, 1'b1, mk(k), 1'b0, 8'd0);
                ev = (k > 4);
                ed = ev ? mk(k - 4) : 48'd0;
            end else begin
                drive(1'b0, 1'b1, mk(999), 1'b0, 8'd0);
                ev = 1'b0;
                ed = 48'd0;
            end
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL stall_valid i=%0d: got %b expected %b", i, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL stall_data i=%0d: got %h expected %h", i, out_data, ed); end
            tick();
        end
    endtask

    task automatic test_reload;
        logic        ev, ep;
        logic [47:0] ed;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, mk(k), 1'b0, 8'd0);
            tick();
        end
        drive(1'b1, 1'b1, mk('hAA), 1'b1, 8'd2);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_cycle_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== mk(3)) begin errors++; $display("FAIL load_cycle_data: got %h expected %h", out_data, mk(3)); end
        tick();
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1, 1'b1, mk(50 + j), 1'b0, 8'd0);
            ev = (j > 2);
            ed = ev ? mk(48 + j) : 48'd0;
            ep = (j >= 3);
            @(negedge clk);
            checks++; if (depth !== 8'd2) begin errors++; $display("FAIL reload_depth j=%0d: got %0d expected 2", j, depth); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL reload_valid j=%0d: got %b expected %b", j, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL reload_data j=%0d: got %h expected %h", j, out_data, ed); end
            checks++; if (primed !== ep) begin errors++; $display("FAIL reload_primed j=%0d: got %b expected %b", j, primed, ep); end
            tick();
        end
    endtask

    task automatic test_depth_one;
        logic        ev, ep;
        logic [47:0] ed;
        drive(1'b0, 1'b0, '0, 1'b1, 8'd1);
        tick();
        for (int j = 1; j <= 4; j++) begin
            drive(1'b1, (j != 2), mk(70 + j), 1'b0, 8'd0);
            ev = (j >= 2) && (j != 3);
            ed = ev ? mk(69 + j) : 48'd0;
            ep = (j >= 2);
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL d1_valid j=%0d: got %b expected %b", j, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL d1_data j=%0d: got %h expected %h", j, out_data, ed); end
            checks++; if (primed !== ep) begin errors++; $display("FAIL d1_primed j=%0d: got %b expected %b", j, primed, ep); end
            tick();
        end
    endtask

    task automatic test_bypass_and_max;
        logic        ev;
        logic [47:0] ed;
        drive(1'b0, 1'b0, '0, 1'b1, 8'd0);
        tick();
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: begin drive(1'b1, 1'b1, mk(5), 1'b0, 8'd0); ev = 1'b1; ed = mk(5); end
                1: begin drive(1'b1, 1'b0, mk(6), 1'b0, 8'd0); ev = 1'b0; ed = 48'd0; end
                default: begin drive(1'b0, 1'b1, mk(7), 1'b0, 8'd0); ev = 1'b0; ed = 48'd0; end
            endcase
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL bypass_valid t=%0d: got %b expected %b", t, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL bypass_data t=%0d: got %h expected %h", t, out_data, ed); end
            checks++; if (primed !== 1'b1) begin errors++; $display("FAIL bypass_primed t=%0d: got %b expected 1", t, primed); end
            checks++; if (depth !== 8'd0) begin errors++; $display("FAIL bypass_depth t=%0d: got %0d expected 0", t, depth); end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 8'd200);
        tick();
        for (int k = 1; k <= 131; k++) begin
            drive(1'b1, 1'b1, mk(k), 1'b0, 8'd0);
            ev = (k > 128);
            ed = ev ? mk(k - 128) : 48'd0;
            @(negedge clk);
            if (k == 1) begin
                checks++; if (depth !== 8'd128) begin errors++; $display("FAIL clamp_depth: got %0d expected 128", depth); end
            end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL max_valid k=%0d: got %b expected %b", k, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL max_data k=%0d: got %h expected %h", k, out_data, ed); end
            tick();
        end
    endtask

    task automatic test_bubbles;
        logic [8:1]  pat;
        logic        ev;
        logic [47:0] ed;
        pat = 8'b0000_1101;
        drive(1'b0, 1'b0, '0, 1'b1, 8'd3);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, pat[k], lanes_ab(k), 1'b0, 8'd0);
            ev = (k > 3) && pat[k - 3];
            ed = ev ? lanes_ab(k - 3) : 48'd0;
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL bubble_valid k=%0d: got %b expected %b", k, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL bubble_data k=%0d: got %h expected %h", k, out_data, ed); end
            tick();
        end
    endtask

    task automatic test_load_rst;
        logic        ev;
        logic [47:0] ed;
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, 1'b1, mk(80 + k), 1'b0, 8'd0);
            tick();
        end
        drive(1'b1, 1'b1, mk('h777), 1'b1, 8'd4);
        tick();
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1, 1'b1, mk(90 + j), 1'b0, 8'd0);
            ev = (j > 4);
            ed = ev ? mk(86 + j) : 48'd0;
            @(negedge clk);
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL ldrst_valid j=%0d: got %b expected %b", j, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL ldrst_data j=%0d: got %h expected %h", j, out_data, ed); end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 8'd3);
        tick();
        drive(1'b1, 1'b1, mk(95), 1'b0, 8'd0);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, mk(96), 1'b1, 8'd7);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, mk(97), 1'b0, 8'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 48'd0) begin errors++; $display("FAIL rst_fill_data: got %h expected 0", out_data); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL rst_fill_primed: got %b expected 0", primed); end
        checks++; if (depth !== 8'(DD)) begin errors++; $display("FAIL rst_fill_depth: got %0d expected %0d", depth, DD); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 8'd0);
        test_reset();
        test_fill_run();
        test_stall();
        test_reload();
        test_depth_one();
        test_bypass_and_max();
        test_bubbles();
        test_load_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
